// File: rtl/circuit_pkg.sv
// Shared constants and state encoding for the accumulate-and-double decoder.
package circuit_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CNT_W         = 7;
    localparam int unsigned FRAME_LEN_DEF = 99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/circuit_decoder_dp.sv
// Combinational inverse of the accumulate-and-double recurrence, mod 2^W.
module circuit_decoder_dp #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] y_cur,
    input  logic [W-1:0] y_prev,
    input  logic [W-1:0] a_prev,
    input  logic         first_flag,
    output logic [W-1:0] a_k,
    output logic [W-1:0] x_k
);

    // Undo the doubling and the k==1 bias, then difference the accumulator.
    always_comb begin
        a_k = y_cur - (y_prev << 1) - W'(first_flag);
        x_k = a_k - a_prev;
    end

endmodule

// File: rtl/circuit_decoder.sv
// Frame-based streaming decoder: FSM, sample counter, history and output register.
module circuit_decoder
    import circuit_pkg::*;
#(
    parameter int unsigned W         = DATA_W,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [W-1:0]     y_i,
    input  logic             y_valid,
    output logic             y_ready,
    output logic [W-1:0]     x_o,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     y_prev;
    logic [W-1:0]     a_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [W-1:0]     a_k;
    logic [W-1:0]     x_k;
    logic             accept;
    logic             take;

    assign cnt_inc = cnt + CNT_W'(1);
    assign cnt_o   = cnt;

    circuit_decoder_dp #(.W(W)) u_dp (
        .y_cur      (y_i),
        .y_prev     (y_prev),
        .a_prev     (a_prev),
        .first_flag (cnt == CNT_W'(1)),
        .a_k        (a_k),
        .x_k        (x_k)
    );

    // Handshake decode and next-state selection; start always wins.
    always_comb begin
        state_next = state;
        take       = x_valid & x_ready;
        y_ready    = en & ~start & (state == RUN) & (~x_valid | x_ready);
        accept     = y_valid & y_ready;
        if (en) begin
            if (start) begin
                state_next = RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (accept && (cnt_inc == CNT_W'(FRAME_LEN))) begin
                            state_next = DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State register with done tracking the DONE state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    // History, counter and output register; frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_prev  <= '0;
            a_prev  <= '0;
            cnt     <= '0;
            x_o     <= '0;
            x_valid <= 1'b0;
        end else if (en) begin
            if (start) begin
                y_prev <= '0;
                a_prev <= '0;
                cnt    <= '0;
                if (take) begin
                    x_valid <= 1'b0;
                end
            end else if (accept) begin
                y_prev  <= y_i;
                a_prev  <= a_k;
                cnt     <= cnt_inc;
                x_o     <= x_k;
                x_valid <= 1'b1;
            end else if (take) begin
                x_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_circuit_decoder.sv
// Self-checking bench for circuit_decoder with a behavioural encoder model.
module tb_circuit_decoder;

    localparam int unsigned FL      = 4;
    localparam int unsigned NFRAMES = 250;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [31:0] y_i;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] x_o;
    logic        x_valid;
    logic        x_ready;
    logic [6:0]  cnt_o;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    circuit_decoder #(.W(32), .FRAME_LEN(FL)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .y_i     (y_i),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .x_o     (x_o),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .cnt_o   (cnt_o),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] y, input logic [31:0] xexp, input string tag);
        y_i     = y;
        y_valid = 1'b1;
        x_ready = 1'b1;
        #1 chk({tag, "_yready"}, 32'(y_ready), 32'd1);
        next_cycle();
        y_valid = 1'b0;
        chk({tag, "_x"}, x_o, xexp);
        chk({tag, "_xvalid"}, 32'(x_valid), 32'd1);
    endtask

    task automatic pulse_start(input string tag);
        start   = 1'b1;
        y_valid = 1'b1;
        x_ready = 1'b1;
        #1 chk({tag, "_yready_start"}, 32'(y_ready), 32'd0);
        next_cycle();
        start   = 1'b0;
        y_valid = 1'b0;
    endtask

    logic [31:0] xf [6];
    logic [31:0] yf [6];
    logic [31:0] a_m;
    logic [31:0] y_m;
    logic [31:0] q[$];
    int          nacc;
    int          idx;
    int          cyc;

    initial begin
        rst = 1'b0; en = 1'b1; start = 1'b0;
        y_i = '0; y_valid = 1'b1; x_ready = 1'b0;

        // Reset values
        repeat (2) next_cycle();
        chk("rst_x", x_o, 32'd0);
        chk("rst_xvalid", 32'(x_valid), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_yready", 32'(y_ready), 32'd0);
        rst = 1'b1;
        y_valid = 1'b0;
        next_cycle();
        chk("idle_yready", 32'(y_ready), 32'd0);

        // Basic decode
        pulse_start("basic");
        send(32'd1, 32'd1, "basic0");
        send(32'd6, 32'd2, "basic1");
        send(32'd18, 32'd3, "basic2");
        chk("basic_cnt", 32'(cnt_o), 32'd3);
        chk("basic_done", 32'(done), 32'd0);

        // Wrap-around
        pulse_start("wrap");
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap0");
        send(32'hFFFF_FFFF, 32'h0000_0001, "wrap1");

        // Backpressure
        pulse_start("bp");
        send(32'd1, 32'd1, "bp0");
        x_ready = 1'b0;
        y_i     = 32'd6;
        y_valid = 1'b1;
        repeat (3) begin
            #1 chk("bp_yready", 32'(y_ready), 32'd0);
            next_cycle();
            chk("bp_x_hold", x_o, 32'd1);
            chk("bp_xvalid_hold", 32'(x_valid), 32'd1);
        end
        chk("bp_cnt_hold", 32'(cnt_o), 32'd1);
        send(32'd6, 32'd2, "bp1");
        send(32'd18, 32'd3, "bp2");
        chk("bp_cnt", 32'(cnt_o), 32'd3);

        // Frame end: 6 offered samples, only FL accepted
        a_m = '0; y_m = '0;
        for (int k = 0; k < 6; k++) begin
            xf[k] = 32'(k + 5);
            a_m   = a_m + xf[k];
            y_m   = (y_m << 1) + a_m + ((k == 1) ? 32'd1 : 32'd0);
            yf[k] = y_m;
        end
        pulse_start("fe");
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            y_i     = yf[nacc];
            y_valid = 1'b1;
            x_ready = 1'b1;
            #1;
            if (y_ready) nacc++;
            next_cycle();
        end
        chk("fe_accepts", 32'(nacc), 32'(FL));
        chk("fe_done", 32'(done), 32'd1);
        chk("fe_cnt", 32'(cnt_o), 32'(FL));
        chk("fe_last_x", x_o, xf[FL-1]);
        chk("fe_yready", 32'(y_ready), 32'd0);
        pulse_start("fe_restart");
        chk("fe_restart_cnt", 32'(cnt_o), 32'd0);
        chk("fe_restart_done", 32'(done), 32'd0);
        chk("fe_restart_xvalid", 32'(x_valid), 32'd0);
        y_valid = 1'b1;
        #1 chk("fe_restart_run", 32'(y_ready), 32'd1);
        y_valid = 1'b0;

        // Enable dropped mid-frame
        send(32'd1, 32'd1, "en0");
        en      = 1'b0;
        y_i     = 32'd6;
        y_valid = 1'b1;
        x_ready = 1'b1;
        repeat (3) begin
            #1 chk("en_yready", 32'(y_ready), 32'd0);
            next_cycle();
            chk("en_xvalid_hold", 32'(x_valid), 32'd1);
            chk("en_x_hold", x_o, 32'd1);
            chk("en_cnt_hold", 32'(cnt_o), 32'd1);
        end
        en = 1'b1;
        send(32'd6, 32'd2, "en1");

        // Start mid-frame clears history
        pulse_start("mid");
        send(32'd1, 32'd1, "mid0");
        chk("mid_cnt", 32'(cnt_o), 32'd1);

        // Reset mid-frame
        rst     = 1'b0;
        y_valid = 1'b0;
        next_cycle();
        chk("mrst_x", x_o, 32'd0);
        chk("mrst_xvalid", 32'(x_valid), 32'd0);
        chk("mrst_cnt", 32'(cnt_o), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst     = 1'b1;
        y_valid = 1'b1;
        #1 chk("mrst_yready", 32'(y_ready), 32'd0);
        y_valid = 1'b0;
        next_cycle();

        // Random round-trip over many frames
        q.delete();
        for (int f = 0; f < int'(NFRAMES); f++) begin
            a_m = '0; y_m = '0;
            for (int k = 0; k < int'(FL); k++) begin
                xf[k] = $urandom;
                a_m   = a_m + xf[k];
                y_m   = (y_m << 1) + a_m + ((k == 1) ? 32'd1 : 32'd0);
                yf[k] = y_m;
            end
            start   = 1'b1;
            en      = 1'b1;
            y_valid = 1'($urandom_range(0, 1));
            y_i     = $urandom;
            x_ready = 1'($urandom_range(0, 1));
            #1 chk("rnd_start_yready", 32'(y_ready), 32'd0);
            if (x_valid && x_ready) begin
                if (q.size() == 0) chk("rnd_spurious", 32'(x_valid), 32'd0);
                else begin
                    chk("rnd_x", x_o, q[0]);
                    void'(q.pop_front());
                end
            end
            next_cycle();
            start = 1'b0;
            chk("rnd_xvalid", 32'(x_valid), 32'(q.size() != 0));
            idx = 0;
            cyc = 0;
            while (idx < int'(FL) && cyc < 300) begin
                en      = ($urandom_range(0, 9) != 0);
                y_valid = ($urandom_range(0, 3) != 0);
                y_i     = y_valid ? yf[idx] : $urandom;
                x_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (en && x_valid && x_ready) begin
                    if (q.size() == 0) chk("rnd_spurious", 32'(x_valid), 32'd0);
                    else begin
                        chk("rnd_x", x_o, q[0]);
                        void'(q.pop_front());
                    end
                end
                if (y_valid && y_ready) begin
                    q.push_back(xf[idx]);
                    idx++;
                end
                next_cycle();
                chk("rnd_xvalid", 32'(x_valid), 32'(q.size() != 0));
                cyc++;
            end
            if (idx < int'(FL)) chk("rnd_timeout_accepts", 32'(idx), 32'(FL));
            chk("rnd_done", 32'(done), 32'd1);
            chk("rnd_cnt", 32'(cnt_o), 32'(FL));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
